// File: rtl/svm_pkg.sv
// svm_pkg: shared widths, FSM state encoding and default coefficients
// for the linear SVM fall-detection classifier.
//   FEAT_W  : width of one signed Q8.8 feature / weight
//   NFEAT   : number of features per classification
//   PROD_W  : width of one Q16.16 product
//   ACC_W   : accumulator width, wide enough that 7 full-scale products
//             plus the bias can never wrap
package svm_pkg;

    localparam int FEAT_W = 16;
    localparam int NFEAT  = 7;
    localparam int PROD_W = 2 * FEAT_W;
    localparam int ACC_W  = 36;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic signed [FEAT_W-1:0] DEF_WEIGHT = 16'sh0100;       // 1.0 in Q8.8
    localparam logic signed [PROD_W-1:0] DEF_BIAS   = -32'sh0003_0000; // -3.0 in Q16.16

endpackage

// File: rtl/svm_mac.sv
// svm_mac: signed 16x16 multiply feeding a registered 36-bit accumulator.
// Ports:
//   i_clk, i_rst  : clock, asynchronous active-high reset
//   i_clear       : synchronous clear of the accumulator (highest priority)
//   i_load        : synchronous load of i_load_val
//   i_en          : accumulate i_a * i_b
//   i_a, i_b      : signed Q8.8 operands
//   i_load_val    : signed value loaded on i_load
//   o_acc         : registered accumulator
module svm_mac
    import svm_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clear,
    input  logic                     i_load,
    input  logic                     i_en,
    input  logic signed [FEAT_W-1:0] i_a,
    input  logic signed [FEAT_W-1:0] i_b,
    input  logic signed [ACC_W-1:0]  i_load_val,
    output logic signed [ACC_W-1:0]  o_acc
);

    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  r_acc;

    // Widen the operands before multiplying so the full 32-bit signed
    // product is kept, then sign-extend into the accumulator width.
    assign w_prod     = PROD_W'(i_a) * PROD_W'(i_b);
    assign w_prod_ext = ACC_W'(w_prod);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_load) begin
            r_acc <= i_load_val;
        end else if (i_en) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/svm_inference.sv
// svm_inference: linear SVM decision stage. On an accepted start the seven
// features are latched, the accumulator is loaded with BIAS, then one
// weight*feature product is accumulated per cycle. The result
// (score > 0) is registered one cycle after the last MAC, with a one-cycle
// done pulse.
// Ports:
//   clk            : clock, rising edge
//   reset_n        : asynchronous reset, ACTIVE-HIGH despite the legacy name
//   start          : request, sampled only while idle
//   feature_0..6   : signed Q8.8 features, captured on the accepted start edge
//   fall_detected  : registered classification, held until the next accepted start
//   done           : one-cycle completion pulse
//   o_dbg_state    : current FSM state, for observation only
// Handshake: start is a request that is honoured only in IDLE; there is no
// back-pressure, a start seen in MAC or FIN is dropped, and done marks the
// single cycle in which fall_detected first carries the new result.
module svm_inference
    import svm_pkg::*;
#(
    parameter logic signed [FEAT_W-1:0] W0   = DEF_WEIGHT,
    parameter logic signed [FEAT_W-1:0] W1   = DEF_WEIGHT,
    parameter logic signed [FEAT_W-1:0] W2   = DEF_WEIGHT,
    parameter logic signed [FEAT_W-1:0] W3   = DEF_WEIGHT,
    parameter logic signed [FEAT_W-1:0] W4   = DEF_WEIGHT,
    parameter logic signed [FEAT_W-1:0] W5   = DEF_WEIGHT,
    parameter logic signed [FEAT_W-1:0] W6   = DEF_WEIGHT,
    parameter logic signed [PROD_W-1:0] BIAS = DEF_BIAS
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic signed [FEAT_W-1:0] feature_0,
    input  logic signed [FEAT_W-1:0] feature_1,
    input  logic signed [FEAT_W-1:0] feature_2,
    input  logic signed [FEAT_W-1:0] feature_3,
    input  logic signed [FEAT_W-1:0] feature_4,
    input  logic signed [FEAT_W-1:0] feature_5,
    input  logic signed [FEAT_W-1:0] feature_6,
    output logic                     fall_detected,
    output logic                     done,
    output state_t                   o_dbg_state
);

    state_t                    r_state;
    state_t                    w_next_state;
    logic [2:0]                r_idx;
    logic signed [FEAT_W-1:0]  r_feat [NFEAT];
    logic                      r_fall;
    logic                      r_done;

    logic                      w_accept;
    logic                      w_mac_en;
    logic                      w_fin;
    logic signed [FEAT_W-1:0]  w_weight;
    logic signed [FEAT_W-1:0]  w_feature;
    logic signed [ACC_W-1:0]   w_acc;
    logic                      w_positive;

    // Next-state and control decode
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_mac_en     = 1'b0;
        w_fin        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = S_MAC;
                end
            end
            S_MAC: begin
                w_mac_en = 1'b1;
                if (r_idx == 3'd6) begin
                    w_next_state = S_FIN;
                end
            end
            S_FIN: begin
                w_fin        = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Operand select for the current MAC step
    always_comb begin
        w_weight  = '0;
        w_feature = '0;
        case (r_idx)
            3'd0: begin w_weight = W0; w_feature = r_feat[0]; end
            3'd1: begin w_weight = W1; w_feature = r_feat[1]; end
            3'd2: begin w_weight = W2; w_feature = r_feat[2]; end
            3'd3: begin w_weight = W3; w_feature = r_feat[3]; end
            3'd4: begin w_weight = W4; w_feature = r_feat[4]; end
            3'd5: begin w_weight = W5; w_feature = r_feat[5]; end
            3'd6: begin w_weight = W6; w_feature = r_feat[6]; end
            default: begin w_weight = '0; w_feature = '0; end
        endcase
    end

    svm_mac u_mac (
        .i_clk      (clk),
        .i_rst      (reset_n),
        .i_clear    (1'b0),
        .i_load     (w_accept),
        .i_en       (w_mac_en),
        .i_a        (w_weight),
        .i_b        (w_feature),
        .i_load_val (ACC_W'(BIAS)),
        .o_acc      (w_acc)
    );

    // Strictly positive: sign bit clear and not all-zero, so a score of
    // exactly zero classifies as no fall.
    assign w_positive = ~w_acc[ACC_W-1] && (w_acc != '0);

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_fall  <= 1'b0;
            r_done  <= 1'b0;
            for (int i = 0; i < NFEAT; i++) begin
                r_feat[i] <= '0;
            end
        end else begin
            r_state <= w_next_state;
            r_done  <= w_fin;
            if (w_accept) begin
                r_idx     <= '0;
                r_fall    <= 1'b0;
                r_feat[0] <= feature_0;
                r_feat[1] <= feature_1;
                r_feat[2] <= feature_2;
                r_feat[3] <= feature_3;
                r_feat[4] <= feature_4;
                r_feat[5] <= feature_5;
                r_feat[6] <= feature_6;
            end
            if (w_mac_en) begin
                r_idx <= r_idx + 3'd1;
            end
            if (w_fin) begin
                r_fall <= w_positive;
            end
        end
    end

    assign fall_detected = r_fall;
    assign done          = r_done;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_svm_inference.sv
module tb_svm_inference;
  import svm_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] feat [7];
  logic        fall_detected;
  logic        done;
  state_t      dbg_state;

  int n_cmp;
  int n_err;
  logic [0:0] exp_q[$];

  svm_inference dut (
    .clk           (clk),
    .reset_n       (rst),
    .start         (start),
    .feature_0     (feat[0]),
    .feature_1     (feat[1]),
    .feature_2     (feat[2]),
    .feature_3     (feat[3]),
    .feature_4     (feat[4]),
    .feature_5     (feat[5]),
    .feature_6     (feat[6]),
    .fall_detected (fall_detected),
    .done          (done),
    .o_dbg_state   (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input longint got, input longint want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Reference: score in Q16.16 = -3.0 + sum(1.0 * f_i); with unit weights
  // each Q8.8 feature contributes f*256 in Q16.16.
  function automatic logic model_fall();
    longint score;
    score = -3 * 65536;
    for (int i = 0; i < 7; i++) begin
      score += 256 * longint'($signed(feat[i]));
    end
    return score > 0;
  endfunction

  task automatic set_all(input logic [15:0] v);
    for (int i = 0; i < 7; i++) feat[i] = v;
  endtask

  task automatic scramble();
    for (int i = 0; i < 7; i++) feat[i] = 16'($urandom_range(0, 65535));
  endtask

  // Pulse start for one edge; returns just after the accepting edge E0.
  task automatic start_run(input bit push);
    @(negedge clk);
    start = 1'b1;
    if (push) exp_q.push_back(model_fall());
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called just after E0: expects done at E8, one cycle wide.
  task automatic wait_done(input string tag);
    int lat;
    logic want;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      check({tag, "_done_timeout"}, 0, 1);
    end else begin
      check({tag, "_latency"}, lat, 8);
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
      check({tag, "_fall"}, fall_detected, want);
      @(negedge clk);
      check({tag, "_done_width"}, done, 0);
    end
  endtask

  task automatic count_dones(input int cycles, output int cnt, output logic last_fall);
    cnt = 0;
    last_fall = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (done) begin
        cnt++;
        last_fall = fall_detected;
      end
    end
  endtask

  initial begin
    int cnt;
    logic lf;
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    start = 1'b0;
    set_all(16'h0000);
    #50;
    check("rst_done", done, 0);
    check("rst_fall", fall_detected, 0);
    check("rst_state", dbg_state, S_IDLE);
    @(negedge clk);
    rst = 1'b0;

    // all 1.0 -> +4.0
    set_all(16'h0100);
    start_run(1);
    scramble();
    wait_done("ones");
    @(negedge clk);
    check("ones_fall_hold", fall_detected, 1);

    // all zero -> -3.0
    set_all(16'h0000);
    start_run(1);
    wait_done("zeros");

    // exactly zero score, then just above
    set_all(16'h0000);
    for (int i = 0; i < 3; i++) feat[i] = 16'h0100;
    start_run(1);
    wait_done("score_zero");
    feat[0] = 16'h0101;
    start_run(1);
    wait_done("score_pos_lsb");

    // extremes
    set_all(16'h7FFF);
    start_run(1);
    wait_done("max_pos");
    set_all(16'h8000);
    start_run(1);
    wait_done("max_neg");

    // start re-pulsed at E3 must be ignored
    set_all(16'h0100);
    start_run(1);
    @(negedge clk);
    @(negedge clk);
    set_all(16'h0000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    count_dones(14, cnt, lf);
    check("restart_done_count", cnt, 1);
    check("restart_fall", lf, exp_q.size() > 0 ? exp_q.pop_front() : 1'bx);
    check("restart_state", dbg_state, S_IDLE);

    // async reset while a positive result is held
    check("pre_rst_fall", fall_detected, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("idle_rst_fall", fall_detected, 0);
    @(negedge clk);
    rst = 1'b0;

    // async reset at E4 of a positive run
    set_all(16'h0100);
    start_run(0);
    @(posedge clk);        // E1
    @(posedge clk);        // E2
    @(posedge clk);        // E3
    @(posedge clk);        // E4
    #1 rst = 1'b1;
    #1;
    check("midrst_fall", fall_detected, 0);
    check("midrst_done", done, 0);
    check("midrst_state", dbg_state, S_IDLE);
    @(negedge clk);
    rst = 1'b0;
    count_dones(12, cnt, lf);
    check("midrst_no_done", cnt, 0);
    start_run(1);
    wait_done("after_rst");

    // start held high: back-to-back runs every 9 cycles
    set_all(16'h0100);
    feat[3] = 16'hFC00;
    @(negedge clk);
    start = 1'b1;
    exp_q.push_back(model_fall());
    exp_q.push_back(model_fall());
    @(negedge clk);
    wait_done("held_1");
    start = 1'b0;
    wait_done("held_2");

    // randomized features, inputs scrambled after the latch edge
    for (int n = 0; n < 40; n++) begin
      if (n % 2 == 0) begin
        scramble();
      end else begin
        for (int i = 0; i < 7; i++) begin
          feat[i] = 16'($urandom_range(0, 16'h0180));
          if ($urandom_range(0, 3) == 0) feat[i] = -feat[i];
        end
      end
      start_run(1);
      scramble();
      wait_done("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/svm_inference.md
# svm_inference

Linear support-vector-machine classifier for the fall-detection pipeline. Takes seven signed Q8.8 features from the feature-extraction stage on a `start` pulse and computes the decision score with one multiply-accumulate per cycle. Raises `fall_detected` when the score is strictly positive, and pulses `done`. It is the final decision stage before the alarm/report logic.

## Interface
Parameters:
- `W0`…`W6`, default `16'sh0100` (1.0): signed Q8.8 weight per feature.
- `BIAS`, default `-32'sh0003_0000` (−3.0): signed Q16.16 intercept.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous reset, active-high. The legacy name is kept; asserting it high resets the block.
- `start`  in  1  request. Sampled only in IDLE.
- `feature_0`…`feature_6`  in  16 each  signed Q8.8 features. Captured on the accepted `start` edge.
- `fall_detected`  out  1  classification result. Holds until the next accepted `start`.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Score = BIAS + Σ Wi·feature_i, all signed.
- Each product is 16×16 → 32-bit Q16.16.
- Accumulator is 36 bits signed, so there is no overflow: 7×2^30 + |BIAS| < 2^35.
- No saturation and no rounding.
- `fall_detected` = (score > 0). A score of exactly 0 gives 0.
- States:
  - IDLE: wait for `start`. On an accepted `start`, latch all features, load the accumulator with sign-extended BIAS, clear index and `fall_detected`, go to MAC.
  - MAC: accumulator += W[idx]·feat[idx], idx++. After idx 6, go to FIN.
  - FIN: `fall_detected` ← (acc > 0), `done` ← 1, go to IDLE.
- `start` outside IDLE is ignored. It is neither queued nor allowed to restart the computation.
- Feature inputs may change freely after the `start` edge.
- Reset at any time, including mid-MAC:
  - state IDLE;
  - accumulator, index and feature latches 0;
  - `fall_detected` 0, `done` 0.

## Timing
- Edge E0: `start` sampled high in IDLE; features latched.
- Edges E1…E7: one MAC each, features 0…6.
- Edge E8: FIN registers the result. `done` and `fall_detected` are valid from E8.
- `done` is high for exactly one cycle and falls at E9.
- A new `start` is accepted from E9 onward. Maximum throughput is one classification per 9 cycles.
- `start` held high continuously re-triggers at each return to IDLE.
- All outputs are registered. There are no combinational paths from input to output.

## Structure
- Package `svm_pkg` holds:
  - `FEAT_W=16`, `NFEAT=7`, `ACC_W=36`;
  - the state enum (IDLE, MAC, FIN);
  - default weight/bias constants.
- One sub-module, `svm_mac`: a registered signed 16×16 multiply with a 36-bit accumulate and synchronous load/clear. Muxed feature/weight select lives in the top level.

## Test plan
Default parameters throughout.
- Reset held 50 ns, then all features `0x0100`, `start` pulse → score +4.0. After 8 cycles: `done`=1 for 1 cycle, `fall_detected`=1, and it is still 1 two cycles later.
- All features `0x0000` → score −3.0 → `fall_detected`=0, `done` at E8.
- Boundary: features 0–2 = `0x0100`, others 0 → score exactly 0 → `fall_detected`=0. Then feature_0 = `0x0101` → `fall_detected`=1.
- Extremes, expected results with no wrap:
  - all `0x7FFF` → `fall_detected`=1;
  - all `0x8000` → `fall_detected`=0.
- `start` re-pulsed at E3 with different features → ignored. The result reflects the first feature set and there is a single `done`.
- Reset asserted at E4 of a positive-score run:
  - outputs go to 0 immediately (asynchronous);
  - no `done` follows;
  - a fresh `start` after release produces a correct result at 8 cycles.
